// File: rtl/uart_rx_fifo_if.sv
// Receive-side ready/valid bus of the UART receiver: FIFO head data, occupancy and pop strobe.
// The receiver uses the master modport; the consumer uses the slave modport.
interface uart_rx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_BITS-1:0] rx_data_o;
  logic                 rx_valid_o;
  logic                 rx_ready_i;
  logic [LW-1:0]        fifo_level_o;

  modport master (
    output rx_data_o,
    output rx_valid_o,
    output fifo_level_o,
    input  rx_ready_i
  );

  modport slave (
    input  rx_data_o,
    input  rx_valid_o,
    input  fifo_level_o,
    output rx_ready_i
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver with centre sampling, optional parity and false-start rejection, feeding a
// first-word-fall-through FIFO; framing, parity and overrun errors are one-cycle pulses.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int FIFO_DEPTH   = 8,
  parameter int SYNC_STAGES  = 2
) (
  input  logic           sys_clk_i,
  input  logic           sys_rst_ni,
  input  logic           uart_rx_i,
  uart_rx_fifo_if.master rx_bus,
  output logic           busy_o,
  output logic           frame_err_o,
  output logic           parity_err_o,
  output logic           overrun_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t                 state_reg, state_next;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   line_prev_reg;
  logic                   line_s;
  logic [CW-1:0]          baud_cnt_reg, baud_cnt_next;
  logic [BW-1:0]          bit_cnt_reg, bit_cnt_next;
  logic [DATA_BITS-1:0]   shift_reg, shift_next;
  logic                   parity_bit_reg, parity_bit_next;
  logic                   tick;
  logic                   parity_ok;
  logic                   frame_done;
  logic                   frame_err_det;
  logic                   parity_err_det;

  logic [AW:0]            wptr_reg, rptr_reg;
  logic [AW:0]            level;
  logic [DATA_BITS-1:0]   mem_reg [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]  wr_en;
  logic                   full;
  logic                   empty;
  logic                   do_pop;
  logic                   do_push;
  logic                   frame_err_reg, parity_err_reg, overrun_reg;

  // Synchronizer idles high so reset never looks like a start edge.
  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) begin
      sync_reg      <= '1;
      line_prev_reg <= 1'b1;
    end else begin
      sync_reg      <= {sync_reg[SYNC_STAGES-2:0], uart_rx_i};
      line_prev_reg <= line_s;
    end
  end

  assign line_s    = sync_reg[SYNC_STAGES-1];
  assign tick      = (baud_cnt_reg == '0);
  assign parity_ok = (PARITY_EN == 0) || ((^shift_reg ^ parity_bit_reg) == 1'(PARITY_ODD));

  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) begin
      state_reg      <= S_IDLE;
      baud_cnt_reg   <= '0;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      parity_bit_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      baud_cnt_reg   <= baud_cnt_next;
      bit_cnt_reg    <= bit_cnt_next;
      shift_reg      <= shift_next;
      parity_bit_reg <= parity_bit_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    baud_cnt_next   = baud_cnt_reg;
    bit_cnt_next    = bit_cnt_reg;
    shift_next      = shift_reg;
    parity_bit_next = parity_bit_reg;
    frame_done      = 1'b0;
    frame_err_det   = 1'b0;
    parity_err_det  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (line_prev_reg && !line_s) begin
          baud_cnt_next = HALF_LOAD;
          bit_cnt_next  = '0;
          state_next    = S_START;
        end
      end
      S_START: begin
        if (!tick) begin
          baud_cnt_next = baud_cnt_reg - 1'b1;
        end else if (line_s) begin
          state_next = S_IDLE;
        end else begin
          baud_cnt_next = FULL_LOAD;
          state_next    = S_DATA;
        end
      end
      S_DATA: begin
        if (!tick) begin
          baud_cnt_next = baud_cnt_reg - 1'b1;
        end else begin
          shift_next    = {line_s, shift_reg[DATA_BITS-1:1]};
          baud_cnt_next = FULL_LOAD;
          if (bit_cnt_reg == LAST_BIT) begin
            bit_cnt_next = '0;
            state_next   = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (!tick) begin
          baud_cnt_next = baud_cnt_reg - 1'b1;
        end else begin
          parity_bit_next = line_s;
          baud_cnt_next   = FULL_LOAD;
          state_next      = S_STOP;
        end
      end
      S_STOP: begin
        if (!tick) begin
          baud_cnt_next = baud_cnt_reg - 1'b1;
        end else if (!line_s) begin
          // A low stop bit may be a line break; hold off until the line recovers.
          frame_err_det = 1'b1;
          state_next    = S_BREAK;
        end else begin
          frame_done     = parity_ok;
          parity_err_det = !parity_ok;
          state_next     = S_IDLE;
        end
      end
      S_BREAK: begin
        if (line_s) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign level   = wptr_reg - rptr_reg;
  assign full    = (level == (AW + 1)'(FIFO_DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = !empty && rx_bus.rx_ready_i;
  // When full, a same-cycle pop frees the slot the write pointer aliases.
  assign do_push = frame_done && (!full || do_pop);

  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_wr_en
    assign wr_en[gi] = do_push && (wptr_reg[AW-1:0] == AW'(gi));
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (wr_en[i]) begin
          mem_reg[i] <= shift_reg;
        end
      end
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) begin
      wptr_reg       <= '0;
      rptr_reg       <= '0;
      frame_err_reg  <= 1'b0;
      parity_err_reg <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      if (do_push) begin
        wptr_reg <= wptr_reg + 1'b1;
      end
      if (do_pop) begin
        rptr_reg <= rptr_reg + 1'b1;
      end
      frame_err_reg  <= frame_err_det;
      parity_err_reg <= parity_err_det;
      overrun_reg    <= frame_done && full && !do_pop;
    end
  end

  assign rx_bus.rx_data_o    = mem_reg[rptr_reg[AW-1:0]];
  assign rx_bus.rx_valid_o   = !empty;
  assign rx_bus.fifo_level_o = level;
  assign busy_o              = (state_reg != S_IDLE);
  assign frame_err_o         = frame_err_reg;
  assign parity_err_o        = parity_err_reg;
  assign overrun_o           = overrun_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench: dut_a is 8N1, dut_b is 8E1; a queue model predicts FIFO contents and errors.
module tb_uart_rx_fifo;
  localparam int CPB   = 16;
  localparam int DB    = 8;
  localparam int DEPTH = 4;
  localparam int SYNC  = 2;
  // Clock edges from start-bit drive to the cycle the received byte is visible.
  localparam int LAT      = SYNC + 1 + CPB / 2 + CPB * (DB + 1);
  // Edges from the start of the stop bit to its sampling edge.
  localparam int STOP_OFS = SYNC + 1 + CPB / 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic line_a = 1'b1;
  logic line_b = 1'b1;
  logic busy_a, ferr_a, perr_a, ovr_a;
  logic busy_b, ferr_b, perr_b, ovr_b;

  uart_rx_fifo_if #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) bus_a ();
  uart_rx_fifo_if #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) bus_b ();

  uart_rx_fifo #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY_EN(0), .PARITY_ODD(0),
    .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)
  ) dut_a (
    .sys_clk_i(clk), .sys_rst_ni(rst_n), .uart_rx_i(line_a), .rx_bus(bus_a),
    .busy_o(busy_a), .frame_err_o(ferr_a), .parity_err_o(perr_a), .overrun_o(ovr_a)
  );

  uart_rx_fifo #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY_EN(1), .PARITY_ODD(0),
    .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)
  ) dut_b (
    .sys_clk_i(clk), .sys_rst_ni(rst_n), .uart_rx_i(line_b), .rx_bus(bus_b),
    .busy_o(busy_b), .frame_err_o(ferr_b), .parity_err_o(perr_b), .overrun_o(ovr_b)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Observed pulse counts and popped bytes.
  int ferr_cnt_a = 0, perr_cnt_a = 0, ovr_cnt_a = 0;
  int ferr_cnt_b = 0, perr_cnt_b = 0, ovr_cnt_b = 0;
  logic [7:0] got_a[$];
  logic [7:0] got_b[$];

  // Model: FIFO contents, expected pop order and expected pulse counts.
  logic [7:0] mf_a[$];
  logic [7:0] mp_a[$];
  logic [7:0] mf_b[$];
  logic [7:0] mp_b[$];
  int e_ferr_a = 0, e_ovr_a = 0, e_perr_b = 0, e_ferr_b = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (ferr_a) ferr_cnt_a <= ferr_cnt_a + 1;
      if (perr_a) perr_cnt_a <= perr_cnt_a + 1;
      if (ovr_a)  ovr_cnt_a  <= ovr_cnt_a + 1;
      if (ferr_b) ferr_cnt_b <= ferr_cnt_b + 1;
      if (perr_b) perr_cnt_b <= perr_cnt_b + 1;
      if (ovr_b)  ovr_cnt_b  <= ovr_cnt_b + 1;
      if (bus_a.rx_valid_o && bus_a.rx_ready_i) got_a.push_back(bus_a.rx_data_o);
      if (bus_b.rx_valid_o && bus_b.rx_ready_i) got_b.push_back(bus_b.rx_data_o);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_line(input bit sel, input logic v);
    if (sel) line_b = v;
    else     line_a = v;
  endtask

  // Frame outcome derived from the line protocol: stop low beats everything, then parity, then capacity.
  task automatic model_frame(input bit sel, input logic [7:0] d, input logic pbit,
                             input logic stopb, input bit pop_at_stop);
    if (!stopb) begin
      if (sel) e_ferr_b++;
      else     e_ferr_a++;
    end else if (sel && (((^d) ^ pbit) != 1'b0)) begin
      e_perr_b++;
    end else if (sel) begin
      if (mf_b.size() < DEPTH) mf_b.push_back(d);
    end else begin
      if (pop_at_stop && mf_a.size() > 0) mp_a.push_back(mf_a.pop_front());
      if (mf_a.size() == DEPTH) e_ovr_a++;
      else mf_a.push_back(d);
    end
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input logic pbit,
                            input logic stopb, input int stop_cycles, input bit pop_at_stop);
    $display("tx dut_%s data=%02h par=%0d stop=%0d", sel ? "b" : "a", d, pbit, stopb);
    set_line(sel, 1'b0);
    tick(CPB);
    for (int i = 0; i < DB; i++) begin
      set_line(sel, d[i]);
      tick(CPB);
    end
    if (sel) begin
      set_line(sel, pbit);
      tick(CPB);
    end
    set_line(sel, stopb);
    for (int j = 1; j <= stop_cycles; j++) begin
      tick(1);
      if (pop_at_stop && j == STOP_OFS - 1) bus_a.rx_ready_i = 1'b1;
      if (pop_at_stop && j == STOP_OFS)     bus_a.rx_ready_i = 1'b0;
    end
    model_frame(sel, d, pbit, stopb, pop_at_stop);
  endtask

  // Pops everything the model holds; reports whether rx_valid_o failed to drop in time.
  task automatic drain(input bit sel, output bit timed_out);
    int n;
    n = 0;
    if (sel) begin
      while (mf_b.size() > 0) mp_b.push_back(mf_b.pop_front());
      bus_b.rx_ready_i = 1'b1;
      while (bus_b.rx_valid_o && n < 4 * DEPTH + 8) begin tick(1); n++; end
      timed_out = bus_b.rx_valid_o;
      bus_b.rx_ready_i = 1'b0;
    end else begin
      while (mf_a.size() > 0) mp_a.push_back(mf_a.pop_front());
      bus_a.rx_ready_i = 1'b1;
      while (bus_a.rx_valid_o && n < 4 * DEPTH + 8) begin tick(1); n++; end
      timed_out = bus_a.rx_valid_o;
      bus_a.rx_ready_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    #20;
    n_vec++; if (bus_a.fifo_level_o !== 3'd0) begin n_err++; $display("FAIL reset_level got=%0d exp=0", bus_a.fifo_level_o); end
    n_vec++; if (bus_a.rx_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", bus_a.rx_valid_o); end
    n_vec++; if (bus_a.rx_data_o !== 8'h00) begin n_err++; $display("FAIL reset_data got=%02h exp=00", bus_a.rx_data_o); end
    n_vec++; if ({busy_a, ferr_a, perr_a, ovr_a, busy_b, ferr_b, perr_b, ovr_b} !== 8'h00) begin
      n_err++; $display("FAIL reset_flags got=%b exp=00000000", {busy_a, ferr_a, perr_a, ovr_a, busy_b, ferr_b, perr_b, ovr_b});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(4);
  endtask

  task automatic test_single_byte();
    int first;
    logic v_next;
    logic [7:0] d_first;
    bit to;
    first = -1; v_next = 1'bx; d_first = 8'hxx;
    bus_a.rx_ready_i = 1'b1;
    fork
      send_frame(1'b0, 8'h54, 1'b0, 1'b1, CPB, 1'b0);
      for (int n = 1; n <= LAT + 10; n++) begin
        tick(1);
        if (first < 0 && bus_a.rx_valid_o) begin first = n; d_first = bus_a.rx_data_o; end
        if (first >= 0 && n == first + 1) v_next = bus_a.rx_valid_o;
      end
    join
    n_vec++; if (first !== LAT) begin n_err++; $display("FAIL single_latency got=%0d exp=%0d", first, LAT); end
    n_vec++; if (d_first !== 8'h54) begin n_err++; $display("FAIL single_data got=%02h exp=54", d_first); end
    n_vec++; if (v_next !== 1'b0) begin n_err++; $display("FAIL single_valid_width got=%b exp=0", v_next); end
    drain(1'b0, to);
    n_vec++; if (to) begin n_err++; $display("FAIL single_drain_timeout got=1 exp=0"); end
    n_vec++; if (got_a.size() !== mp_a.size()) begin n_err++; $display("FAIL single_count got=%0d exp=%0d", got_a.size(), mp_a.size()); end
    n_vec++; if ({ferr_cnt_a, perr_cnt_a, ovr_cnt_a} !== {e_ferr_a, 32'd0, e_ovr_a}) begin
      n_err++; $display("FAIL single_errs got=%0d/%0d/%0d exp=%0d/0/%0d", ferr_cnt_a, perr_cnt_a, ovr_cnt_a, e_ferr_a, e_ovr_a);
    end
    got_a.delete(); mp_a.delete();
  endtask

  task automatic test_burst();
    logic [7:0] msg [4];
    bit to;
    msg = '{8'h54, 8'h45, 8'h53, 8'h54};
    for (int i = 0; i < 4; i++) send_frame(1'b0, msg[i], 1'b0, 1'b1, CPB, 1'b0);
    tick(2);
    n_vec++; if (bus_a.fifo_level_o !== 3'(mf_a.size())) begin n_err++; $display("FAIL burst_level got=%0d exp=%0d", bus_a.fifo_level_o, mf_a.size()); end
    drain(1'b0, to);
    n_vec++; if (to) begin n_err++; $display("FAIL burst_drain_timeout got=1 exp=0"); end
    n_vec++; if (got_a.size() !== 4) begin n_err++; $display("FAIL burst_count got=%0d exp=4", got_a.size()); end
    for (int i = 0; i < 4 && i < got_a.size(); i++) begin
      n_vec++; if (got_a[i] !== mp_a[i]) begin n_err++; $display("FAIL burst_pop%0d got=%02h exp=%02h", i, got_a[i], mp_a[i]); end
    end
    n_vec++; if ({bus_a.fifo_level_o, bus_a.rx_valid_o} !== 4'b0000) begin
      n_err++; $display("FAIL burst_empty got=%0d/%b exp=0/0", bus_a.fifo_level_o, bus_a.rx_valid_o);
    end
    got_a.delete(); mp_a.delete();
  endtask

  task automatic test_overrun();
    int o0;
    bit to;
    for (int pass = 0; pass < 2; pass++) begin
      o0 = ovr_cnt_a;
      for (int i = 1; i <= 4; i++) send_frame(1'b0, 8'(i), 1'b0, 1'b1, CPB, 1'b0);
      n_vec++; if (ovr_cnt_a !== o0) begin n_err++; $display("FAIL ovr%0d_early got=%0d exp=%0d", pass, ovr_cnt_a, o0); end
      send_frame(1'b0, 8'h05, 1'b0, 1'b1, CPB, pass == 1);
      n_vec++; if (ovr_cnt_a !== e_ovr_a) begin n_err++; $display("FAIL ovr%0d_pulse got=%0d exp=%0d", pass, ovr_cnt_a, e_ovr_a); end
      n_vec++; if (bus_a.fifo_level_o !== 3'(mf_a.size())) begin n_err++; $display("FAIL ovr%0d_level got=%0d exp=%0d", pass, bus_a.fifo_level_o, mf_a.size()); end
      drain(1'b0, to);
      n_vec++; if (to) begin n_err++; $display("FAIL ovr%0d_drain_timeout got=1 exp=0", pass); end
      n_vec++; if (got_a.size() !== mp_a.size()) begin n_err++; $display("FAIL ovr%0d_count got=%0d exp=%0d", pass, got_a.size(), mp_a.size()); end
      for (int i = 0; i < mp_a.size() && i < got_a.size(); i++) begin
        n_vec++; if (got_a[i] !== mp_a[i]) begin n_err++; $display("FAIL ovr%0d_pop%0d got=%02h exp=%02h", pass, i, got_a[i], mp_a[i]); end
      end
      got_a.delete(); mp_a.delete();
    end
  endtask

  task automatic test_glitch_framing();
    int f0;
    f0 = ferr_cnt_a;
    set_line(1'b0, 1'b0); tick(4); set_line(1'b0, 1'b1); tick(30);
    n_vec++; if ({busy_a, bus_a.rx_valid_o} !== 2'b00) begin n_err++; $display("FAIL glitch_idle got=%b exp=00", {busy_a, bus_a.rx_valid_o}); end
    n_vec++; if (ferr_cnt_a !== f0) begin n_err++; $display("FAIL glitch_err got=%0d exp=%0d", ferr_cnt_a, f0); end
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 3 * CPB, 1'b0);
    n_vec++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL break_busy got=%b exp=1", busy_a); end
    n_vec++; if (ferr_cnt_a !== e_ferr_a) begin n_err++; $display("FAIL frame_err got=%0d exp=%0d", ferr_cnt_a, e_ferr_a); end
    n_vec++; if (bus_a.fifo_level_o !== 3'(mf_a.size())) begin n_err++; $display("FAIL frame_level got=%0d exp=%0d", bus_a.fifo_level_o, mf_a.size()); end
    set_line(1'b0, 1'b1); tick(SYNC + 2);
    n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL break_release got=%b exp=0", busy_a); end
    tick(CPB);
  endtask

  task automatic test_parity();
    bit to;
    send_frame(1'b1, 8'h54, 1'b1, 1'b1, CPB, 1'b0);
    send_frame(1'b1, 8'h54, 1'b0, 1'b1, CPB, 1'b0);
    for (int i = 0; i < 6; i++) begin
      send_frame(1'b1, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b1, CPB, 1'b0);
      if (mf_b.size() == DEPTH) begin drain(1'b1, to); if (to) begin n_vec++; n_err++; $display("FAIL parity_drain_timeout got=1 exp=0"); end end
    end
    n_vec++; if (perr_cnt_b !== e_perr_b) begin n_err++; $display("FAIL parity_err got=%0d exp=%0d", perr_cnt_b, e_perr_b); end
    n_vec++; if ({ferr_cnt_b, ovr_cnt_b} !== {e_ferr_b, 32'd0}) begin n_err++; $display("FAIL parity_other got=%0d/%0d exp=%0d/0", ferr_cnt_b, ovr_cnt_b, e_ferr_b); end
    drain(1'b1, to);
    n_vec++; if (to) begin n_err++; $display("FAIL parity_final_timeout got=1 exp=0"); end
    n_vec++; if (got_b.size() !== mp_b.size()) begin n_err++; $display("FAIL parity_count got=%0d exp=%0d", got_b.size(), mp_b.size()); end
    for (int i = 0; i < mp_b.size() && i < got_b.size(); i++) begin
      n_vec++; if (got_b[i] !== mp_b[i]) begin n_err++; $display("FAIL parity_pop%0d got=%02h exp=%02h", i, got_b[i], mp_b[i]); end
    end
    got_b.delete(); mp_b.delete();
  endtask

  task automatic test_random();
    bit to;
    int nb;
    for (int r = 0; r < 4; r++) begin
      set_line(1'b0, 1'b0); tick($urandom_range(1, 5)); set_line(1'b0, 1'b1); tick(20);
      nb = $urandom_range(1, 6);
      for (int i = 0; i < nb; i++) send_frame(1'b0, 8'($urandom_range(0, 255)), 1'b0, 1'b1, CPB + $urandom_range(0, 8), 1'b0);
      n_vec++; if (ovr_cnt_a !== e_ovr_a) begin n_err++; $display("FAIL rnd%0d_ovr got=%0d exp=%0d", r, ovr_cnt_a, e_ovr_a); end
      n_vec++; if (bus_a.fifo_level_o !== 3'(mf_a.size())) begin n_err++; $display("FAIL rnd%0d_level got=%0d exp=%0d", r, bus_a.fifo_level_o, mf_a.size()); end
      drain(1'b0, to);
      n_vec++; if (to) begin n_err++; $display("FAIL rnd%0d_drain_timeout got=1 exp=0", r); end
      n_vec++; if (got_a.size() !== mp_a.size()) begin n_err++; $display("FAIL rnd%0d_count got=%0d exp=%0d", r, got_a.size(), mp_a.size()); end
      for (int i = 0; i < mp_a.size() && i < got_a.size(); i++) begin
        n_vec++; if (got_a[i] !== mp_a[i]) begin n_err++; $display("FAIL rnd%0d_pop%0d got=%02h exp=%02h", r, i, got_a[i], mp_a[i]); end
      end
      got_a.delete(); mp_a.delete();
    end
    n_vec++; if (ferr_cnt_a !== e_ferr_a) begin n_err++; $display("FAIL rnd_ferr got=%0d exp=%0d", ferr_cnt_a, e_ferr_a); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    bit to;
    d = 8'h3C;
    send_frame(1'b0, 8'h11, 1'b0, 1'b1, CPB, 1'b0);
    send_frame(1'b0, 8'h22, 1'b0, 1'b1, CPB, 1'b0);
    n_vec++; if (bus_a.fifo_level_o !== 3'd2) begin n_err++; $display("FAIL rstmid_pre_level got=%0d exp=2", bus_a.fifo_level_o); end
    set_line(1'b0, 1'b0); tick(CPB);
    for (int i = 0; i < 3; i++) begin set_line(1'b0, d[i]); tick(CPB); end
    set_line(1'b0, d[3]); tick(5);
    #3 rst_n = 1'b0;
    #1;
    n_vec++; if ({bus_a.fifo_level_o, bus_a.rx_valid_o, busy_a} !== 5'b00000) begin
      n_err++; $display("FAIL rstmid_async got=%0d/%b/%b exp=0/0/0", bus_a.fifo_level_o, bus_a.rx_valid_o, busy_a);
    end
    mf_a.delete();
    set_line(1'b0, 1'b1);
    tick(3);
    rst_n = 1'b1;
    tick(5);
    send_frame(1'b0, d, 1'b0, 1'b1, CPB, 1'b0);
    drain(1'b0, to);
    n_vec++; if (to) begin n_err++; $display("FAIL rstmid_drain_timeout got=1 exp=0"); end
    n_vec++; if (got_a.size() !== 1) begin n_err++; $display("FAIL rstmid_count got=%0d exp=1", got_a.size()); end
    if (got_a.size() > 0) begin
      n_vec++; if (got_a[0] !== mp_a[0]) begin n_err++; $display("FAIL rstmid_data got=%02h exp=%02h", got_a[0], mp_a[0]); end
    end
    got_a.delete(); mp_a.delete();
  endtask

  initial begin
    bus_a.rx_ready_i = 1'b0;
    bus_b.rx_ready_i = 1'b0;
    test_reset();
    test_single_byte();
    test_burst();
    test_overrun();
    test_glitch_framing();
    test_parity();
    test_random();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
